radar_cycle_ctrl: RTL and testbench

RADAR_CYCLE_CTRL -- requirements
Module: radar_cycle_ctrl

---
 rtl/radar_cycle_ctrl.sv | 112 +++++++++++
 tb/tb_radar_cycle_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/radar_cycle_ctrl.sv
// radar_cycle_ctrl: channel-13 radar read sequencer (gate select, settle, 15-bit serial capture, interrupt).
// Optional RADAR_DUALRAIL_CHECK_EN flags err when both rails agree on a SHIFT tick.
module radar_cycle_ctrl (
    input  logic        CLOCK,
    input  logic        rst,
    input  logic        wr_strobe,
    input  logic [3:0]  wr_data,
    input  logic        tick,
    input  logic        rin0,
    input  logic        rin1,
    input  logic        rpt_ack,
    output logic [5:0]  sel,
    output logic        rsync,
    output logic [14:0] rnrad,
    output logic        radrpt,
    output logic        busy,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, SETTLE, SHIFT, DONE} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'd7;
    localparam logic [3:0] SHIFT_LAST  = 4'd14;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_code;
    logic [3:0]  r_cnt;
    logic [14:0] r_shift;
    logic [14:0] r_rnrad;
    logic        r_radrpt;
    logic        r_err;

    logic w_active;
    logic w_code_ok;
    logic w_start;
    logic w_bad;
    logic w_abort;
    logic w_shift_tick;
    logic w_rail_err;

    assign w_active     = (r_state == SETTLE) || (r_state == SHIFT);
    assign w_code_ok    = (wr_data[2:0] != 3'd0) && (wr_data[2:0] != 3'd7);
    assign w_start      = wr_strobe && wr_data[3] && (r_state == IDLE) && w_code_ok;
    assign w_bad        = wr_strobe && wr_data[3] && (r_state == IDLE) && !w_code_ok;
    assign w_abort      = wr_strobe && !wr_data[3] && w_active;
    assign w_shift_tick = tick && (r_state == SHIFT);

`ifdef RADAR_DUALRAIL_CHECK_EN
    assign w_rail_err = w_shift_tick && (rin0 == rin1);
`else
    logic w_unused_rin0;
    assign w_unused_rin0 = rin0;
    assign w_rail_err    = 1'b0;
`endif

    always_ff @(posedge CLOCK) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // NOTE: w_next takes the current state before the case so every path assigns it and no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next = SETTLE;
            SETTLE:  if (w_abort) w_next = IDLE;
                     else if (tick && (r_cnt == SETTLE_LAST)) w_next = SHIFT;
            SHIFT:   if (w_abort) w_next = IDLE;
                     else if (tick && (r_cnt == SHIFT_LAST)) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // One counter serves both phases; it restarts on every state change.
    always_ff @(posedge CLOCK) begin
        if (rst) begin
            r_code   <= '0;
            r_cnt    <= '0;
            r_shift  <= '0;
            r_rnrad  <= '0;
            r_radrpt <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_start) r_code <= wr_data[2:0];

            if (w_next != r_state)     r_cnt <= '0;
            else if (tick && w_active) r_cnt <= r_cnt + 4'd1;

            if (w_shift_tick) r_shift <= {r_shift[13:0], rin1};

            // Setting the interrupt outranks a coincident acknowledge.
            if (r_state == DONE) begin
                r_rnrad  <= r_shift;
                r_radrpt <= 1'b1;
            end else if (rpt_ack) begin
                r_radrpt <= 1'b0;
            end

            if (w_start)                  r_err <= 1'b0;
            else if (w_bad || w_rail_err) r_err <= 1'b1;
        end
    end

    assign busy   = w_active;
    assign sel    = w_active ? (6'd1 << (r_code - 3'd1)) : 6'd0;
    assign rsync  = w_shift_tick;
    assign rnrad  = r_rnrad;
    assign radrpt = r_radrpt;
    assign err    = r_err;

endmodule

// File: tb/tb_radar_cycle_ctrl.sv
// Scoreboard bench for radar_cycle_ctrl: stimulus pushes expected cycle outcomes, a monitor checks each cycle end.
module tb_radar_cycle_ctrl;
    typedef struct {
        logic [5:0]  sel;
        int          rs;
        logic [14:0] rnrad;
        logic        radrpt;
    } exp_t;

    logic        CLOCK = 1'b0;
    logic        rst = 1'b1;
    logic        wr_strobe = 1'b0;
    logic [3:0]  wr_data = '0;
    logic        tick = 1'b0;
    logic        rin0 = 1'b0;
    logic        rin1 = 1'b0;
    logic        rpt_ack = 1'b0;
    logic [5:0]  sel;
    logic        rsync;
    logic [14:0] rnrad;
    logic        radrpt;
    logic        busy;
    logic        err;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t exp_q[$];

    logic [14:0] m_rnrad = '0;
    logic        m_radrpt = 1'b0;
    logic        m_err = 1'b0;

    bit          mon_en = 1'b0;
    bit          mon_prev_busy = 1'b0;
    bit          mon_pending = 1'b0;
    logic [5:0]  mon_sel_or = '0;
    int          mon_rs = 0;
    exp_t        mon_e;

    radar_cycle_ctrl dut (
        .CLOCK     (CLOCK),
        .rst       (rst),
        .wr_strobe (wr_strobe),
        .wr_data   (wr_data),
        .tick      (tick),
        .rin0      (rin0),
        .rin1      (rin1),
        .rpt_ack   (rpt_ack),
        .sel       (sel),
        .rsync     (rsync),
        .rnrad     (rnrad),
        .radrpt    (radrpt),
        .busy      (busy),
        .err       (err)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [5:0] s, input int rs, input logic [14:0] w, input logic rp);
        exp_t e;
        e.sel = s; e.rs = rs; e.rnrad = w; e.radrpt = rp;
        exp_q.push_back(e);
    endtask

    function automatic logic [5:0] onehot(input logic [2:0] code);
        return 6'd1 << (code - 3'd1);
    endfunction

    // Monitor: accumulates gate selects and sync pulses, then scores each cycle one clock after busy drops.
    initial begin
        forever begin
            @(negedge CLOCK);
            if (mon_en) begin
                if (rsync) mon_rs++;
                if (busy) mon_sel_or |= sel;
                if (mon_pending) begin
                    mon_pending = 1'b0;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL sb_pop: cycle ended with nothing expected at %0t", $time);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("sb_sel", 32'(mon_sel_or), 32'(mon_e.sel));
                        check("sb_rsync_count", 32'(mon_rs), 32'(mon_e.rs));
                        check("sb_rnrad", 32'(rnrad), 32'(mon_e.rnrad));
                        check("sb_radrpt", 32'(radrpt), 32'(mon_e.radrpt));
                    end
                    mon_sel_or = '0;
                    mon_rs = 0;
                end else if (mon_prev_busy && !busy) begin
                    mon_pending = 1'b1;
                    check("sel_clear_at_end", 32'(sel), 32'd0);
                end
                mon_prev_busy = busy;
            end
        end
    end

    task automatic clk1();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) clk1();
    endtask

    task automatic write(input logic [3:0] d);
        wr_strobe = 1'b1;
        wr_data = d;
        clk1();
        wr_strobe = 1'b0;
        wr_data = '0;
    endtask

    task automatic pulse_tick(input logic b, input logic r0);
        idle($urandom_range(0, 2));
        tick = 1'b1;
        rin1 = b;
        rin0 = r0;
        clk1();
        tick = 1'b0;
    endtask

    task automatic ack();
        rpt_ack = 1'b1;
        clk1();
        rpt_ack = 1'b0;
        @(negedge CLOCK);
        check("radrpt_after_ack", 32'(radrpt), 32'd0);
        m_radrpt = 1'b0;
    endtask

    // One activation: 8 settle ticks, then up to 15 data ticks (MSB first) or an abort write.
    task automatic run_cycle(input logic [2:0] code, input logic [14:0] word, input int abort_at,
                             input int bad_at, input bit ack_on_done, input bit stray_wr);
        bit   aborted;
        logic b;
        aborted = 1'b0;
        if (abort_at < 0) push_exp(onehot(code), 15, word, 1'b1);
        else              push_exp(onehot(code), abort_at, m_rnrad, m_radrpt);
        write({1'b1, code});
        m_err = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (stray_wr && i == 3) write(4'b1000);
            pulse_tick(1'($urandom), 1'($urandom));
        end
        for (int i = 0; i < 15 && !aborted; i++) begin
            if (i == abort_at) begin
                write({1'b0, 3'($urandom)});
                aborted = 1'b1;
            end else begin
                b = word[14 - i];
`ifdef RADAR_DUALRAIL_CHECK_EN
                if (i == bad_at) m_err = 1'b1;
`endif
                pulse_tick(b, (i == bad_at) ? b : ~b);
            end
        end
        if (!aborted) begin
            if (ack_on_done) begin
                rpt_ack = 1'b1;
                clk1();
                rpt_ack = 1'b0;
            end
            m_rnrad = word;
            m_radrpt = 1'b1;
        end
        idle(3);
        @(negedge CLOCK);
        check("err_after_cycle", 32'(err), 32'(m_err));
        check("busy_after_cycle", 32'(busy), 32'd0);
        tick = 1'b1;
        clk1();
        tick = 1'b0;
    endtask

    initial begin
        logic [14:0] w;
        logic [2:0]  code;
        int          ab;

        @(posedge CLOCK);
        @(negedge CLOCK);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_rsync", 32'(rsync), 32'd0);
        check("rst_rnrad", 32'(rnrad), 32'd0);
        check("rst_radrpt", 32'(radrpt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        clk1();
        rst = 1'b0;
        mon_en = 1'b1;
        idle(2);

        // Fixed alternating word on code 3, then held interrupt and acknowledge.
        run_cycle(3'd3, 15'h5555, -1, -1, 1'b0, 1'b0);
        repeat (10) begin
            @(negedge CLOCK);
            check("radrpt_hold", 32'(radrpt), 32'd1);
        end
        ack();

        // Abort after five data ticks keeps the previous word.
        run_cycle(3'd6, 15'($urandom), 5, -1, 1'b0, 1'b0);

        // Invalid codes set err; a valid start clears it.
        write(4'b1000);
        @(negedge CLOCK);
        check("err_code0", 32'(err), 32'd1);
        check("busy_code0", 32'(busy), 32'd0);
        write(4'b1111);
        @(negedge CLOCK);
        check("err_code7", 32'(err), 32'd1);
        check("busy_code7", 32'(busy), 32'd0);
        push_exp(6'b000001, 0, m_rnrad, m_radrpt);
        write(4'b1001);
        @(negedge CLOCK);
        check("err_cleared", 32'(err), 32'd0);
        check("sel_code1", 32'(sel), 32'b000001);
        write(4'b0001);
        idle(3);

        // Randomized cycles, some aborted, some with an ignored write while busy.
        for (int n = 0; n < 8; n++) begin
            code = 3'($urandom_range(1, 6));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 14)) : -1;
            run_cycle(code, 15'($urandom), ab, -1, 1'b0, 1'($urandom));
            if (m_radrpt) ack();
        end

        // Both rails high on data tick 7; the bit still follows rin1.
        w = 15'($urandom) | 15'h0100;
        run_cycle(3'd2, w, -1, 6, 1'b0, 1'b0);
        check("rnrad_bit8", 32'(rnrad[8]), 32'd1);
        ack();

        // Acknowledge coincident with DONE loses; a new cycle is accepted while the interrupt pends.
        run_cycle(3'd4, 15'($urandom), -1, -1, 1'b1, 1'b0);
        check("radrpt_set_wins", 32'(radrpt), 32'd1);
        run_cycle(3'd5, 15'($urandom), -1, -1, 1'b0, 1'b0);

        // Reset in the middle of SHIFT discards everything.
        push_exp(onehot(3'd1), 5, 15'd0, 1'b0);
        write(4'b1001);
        for (int i = 0; i < 8; i++) pulse_tick(1'($urandom), 1'($urandom));
        for (int i = 0; i < 5; i++) pulse_tick(1'b1, 1'b0);
        rst = 1'b1;
        clk1();
        rst = 1'b0;
        m_rnrad = '0;
        m_radrpt = 1'b0;
        m_err = 1'b0;
        @(negedge CLOCK);
        check("midrst_sel", 32'(sel), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_rsync", 32'(rsync), 32'd0);
        check("midrst_rnrad", 32'(rnrad), 32'd0);
        check("midrst_radrpt", 32'(radrpt), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        idle(5);

        check("sb_all_cycles_seen", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
